bidir_chan_ctrl: RTL and testbench

Parametrised multi-channel bidirectional pad controller that sits between core logic and the per-channel IO_BUF / IO_BUF_DS instances at the top level. Each channel has four jobs:
- Deserialises pad input into words while receiving.
- Serialises words onto the pad while transmitting.
- Drives the buffer T pin.
- Enforces a programmable dead-time on every direction change so the pad is never driven during turnaround.

---
 rtl/bidir_chan_ctrl.sv | 146 ++++++++++++++
 tb/tb_bidir_chan_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bidir_chan_ctrl.sv
// Multi-channel bidirectional pad controller: per-channel serial RX/TX with
// tristated dead-time on every direction change, driving IO_BUF T/I pins.
module bidir_chan_ctrl #(
  parameter int CHANNELS    = 2,
  parameter int DEPTH       = 4,
  parameter int TURN_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         dir_req,
  input  logic [CHANNELS*DEPTH-1:0]   tx_word,
  input  logic [CHANNELS-1:0]         tx_valid,
  output logic [CHANNELS-1:0]         tx_ready,
  output logic [CHANNELS*DEPTH-1:0]   rx_word,
  output logic [CHANNELS-1:0]         rx_valid,
  input  logic [CHANNELS-1:0]         io_i,
  output logic [CHANNELS-1:0]         io_o,
  output logic [CHANNELS-1:0]         io_t,
  output logic [2*CHANNELS-1:0]       dir_state
);

  localparam int CW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(DEPTH - 1);
  localparam int TL = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;
  localparam logic [3:0]    TURN_LAST = 4'(TL);

  localparam logic [1:0] ST_RX      = 2'd0;
  localparam logic [1:0] ST_TURN_TX = 2'd1;
  localparam logic [1:0] ST_TX      = 2'd2;
  localparam logic [1:0] ST_TURN_RX = 2'd3;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [1:0]       r_state;
    logic [CW-1:0]    r_bitcnt;
    logic [DEPTH-2:0] r_rxsh;
    logic [DEPTH-1:0] r_rxword;
    logic             r_rxvld;
    logic [DEPTH-2:0] r_txsh;
    logic [CW-1:0]    r_txidx;
    logic             r_busy;
    logic             r_ioo;
    logic             r_iot;
    logic [3:0]       r_turn;
    logic             w_last;
    logic             w_ready;
    logic             w_hs;
    logic [DEPTH-1:0] w_capt;

    // r_txidx is the index of the bit currently on io_o while a word is in flight
    assign w_last  = r_busy && (r_txidx == '0);
    assign w_ready = (r_state == ST_TX) && dir_req[c] && (!r_busy || w_last);
    assign w_hs    = w_ready && tx_valid[c];
    assign w_capt  = {r_rxsh, io_i[c]};

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state  <= ST_RX;
        r_bitcnt <= '0;
        r_rxsh   <= '0;
        r_rxword <= '0;
        r_rxvld  <= 1'b0;
        r_txsh   <= '0;
        r_txidx  <= '0;
        r_busy   <= 1'b0;
        r_ioo    <= 1'b0;
        r_iot    <= 1'b1;
        r_turn   <= '0;
      end else begin
        r_rxvld <= 1'b0;
        case (r_state)
          ST_RX: begin
            r_rxsh <= w_capt[DEPTH-2:0];
            if (r_bitcnt == BIT_LAST) begin
              r_rxword <= w_capt;
              r_rxvld  <= 1'b1;
              r_bitcnt <= '0;
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
            // a word completing on this edge is still delivered above
            if (dir_req[c]) begin
              r_bitcnt <= '0;
              r_rxsh   <= '0;
              r_turn   <= '0;
              r_busy   <= 1'b0;
              if (TURN_CYCLES == 0) begin
                r_state <= ST_TX;
                r_iot   <= 1'b0;
              end else begin
                r_state <= ST_TURN_TX;
              end
            end
          end
          ST_TURN_TX: begin
            if (!dir_req[c]) begin
              r_state  <= ST_RX;
              r_bitcnt <= '0;
            end else if (r_turn == TURN_LAST) begin
              r_state <= ST_TX;
              r_iot   <= 1'b0;
            end else begin
              r_turn <= r_turn + 1'b1;
            end
          end
          ST_TX: begin
            if (w_hs) begin
              r_txsh  <= tx_word[c*DEPTH +: DEPTH-1];
              r_ioo   <= tx_word[c*DEPTH + DEPTH-1];
              r_txidx <= BIT_LAST;
              r_busy  <= 1'b1;
            end else if (r_busy && !w_last) begin
              r_ioo   <= r_txsh[DEPTH-2];
              r_txsh  <= r_txsh << 1;
              r_txidx <= r_txidx - 1'b1;
            end else begin
              r_busy <= 1'b0;
              r_ioo  <= 1'b0;
              if (!dir_req[c]) begin
                r_iot    <= 1'b1;
                r_turn   <= '0;
                r_bitcnt <= '0;
                r_rxsh   <= '0;
                r_state  <= (TURN_CYCLES == 0) ? ST_RX : ST_TURN_RX;
              end
            end
          end
          default: begin
            if (r_turn == TURN_LAST) begin
              r_state <= ST_RX;
            end else begin
              r_turn <= r_turn + 1'b1;
            end
          end
        endcase
      end
    end

    assign tx_ready[c]                = w_ready;
    assign rx_word[c*DEPTH +: DEPTH]  = r_rxword;
    assign rx_valid[c]                = r_rxvld;
    assign io_o[c]                    = r_ioo;
    assign io_t[c]                    = r_iot;
    assign dir_state[2*c +: 2]        = r_state;
  end

endmodule

// File: tb/tb_bidir_chan_ctrl.sv
// Bench for bidir_chan_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based behavioural channel model.
module tb_bidir_chan_ctrl;

  localparam int CH   = 2;
  localparam int DP   = 4;
  localparam int TURN = 2;

  localparam int S_RX  = 0;
  localparam int S_TTX = 1;
  localparam int S_TX  = 2;
  localparam int S_TRX = 3;

  logic               clk;
  logic               reset;
  logic [CH-1:0]      dir_req;
  logic [CH*DP-1:0]   tx_word;
  logic [CH-1:0]      tx_valid;
  logic [CH-1:0]      tx_ready;
  logic [CH*DP-1:0]   rx_word;
  logic [CH-1:0]      rx_valid;
  logic [CH-1:0]      io_i;
  logic [CH-1:0]      io_o;
  logic [CH-1:0]      io_t;
  logic [2*CH-1:0]    dir_state;

  int checks;
  int errors;

  bidir_chan_ctrl #(.CHANNELS(CH), .DEPTH(DP), .TURN_CYCLES(TURN)) dut (
    .clk(clk), .reset(reset), .dir_req(dir_req), .tx_word(tx_word),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_word(rx_word),
    .rx_valid(rx_valid), .io_i(io_i), .io_o(io_o), .io_t(io_t),
    .dir_state(dir_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model state, one entry per channel
  int          m_st[CH];
  int          m_left[CH];
  bit          m_inflight[CH];
  bit          m_ioo[CH];
  bit          m_rxv[CH];
  logic [DP-1:0] m_rxw[CH];
  bit          rxq[CH][$];
  bit          txq[CH][$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_ready(input int c, input logic d);
    return (m_st[c] == S_TX) && d && (!m_inflight[c] || txq[c].size() == 0);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_st[c] = S_RX; m_left[c] = 0; m_inflight[c] = 0; m_ioo[c] = 0;
      m_rxv[c] = 0; m_rxw[c] = '0;
      rxq[c].delete(); txq[c].delete();
    end
  endtask

  task automatic model_step(input logic [CH-1:0] d, input logic [CH-1:0] v,
                            input logic [CH-1:0] i, input logic [CH*DP-1:0] w);
    logic rdy;
    int   acc;
    for (int c = 0; c < CH; c++) begin
      rdy = m_ready(c, d[c]);
      m_rxv[c] = 0;
      case (m_st[c])
        S_RX: begin
          rxq[c].push_back(i[c]);
          if (rxq[c].size() == DP) begin
            acc = 0;
            for (int k = 0; k < DP; k++) acc = acc * 2 + int'(rxq[c][k]);
            m_rxw[c] = DP'(acc);
            m_rxv[c] = 1;
            rxq[c].delete();
          end
          if (d[c]) begin
            rxq[c].delete();
            m_inflight[c] = 0;
            if (TURN == 0) m_st[c] = S_TX;
            else begin m_st[c] = S_TTX; m_left[c] = TURN; end
          end
        end
        S_TTX: begin
          if (!d[c]) m_st[c] = S_RX;
          else begin
            m_left[c]--;
            if (m_left[c] == 0) m_st[c] = S_TX;
          end
        end
        S_TX: begin
          if (rdy && v[c]) begin
            txq[c].delete();
            for (int b = DP - 2; b >= 0; b--) txq[c].push_back(w[c*DP + b]);
            m_ioo[c] = w[c*DP + DP - 1];
            m_inflight[c] = 1;
          end else if (m_inflight[c] && txq[c].size() > 0) begin
            m_ioo[c] = txq[c].pop_front();
          end else begin
            m_inflight[c] = 0;
            m_ioo[c] = 0;
            if (!d[c]) begin
              rxq[c].delete();
              if (TURN == 0) m_st[c] = S_RX;
              else begin m_st[c] = S_TRX; m_left[c] = TURN; end
            end
          end
        end
        default: begin
          m_left[c]--;
          if (m_left[c] == 0) m_st[c] = S_RX;
        end
      endcase
    end
  endtask

  task automatic compare_outputs();
    for (int c = 0; c < CH; c++) begin
      check_val($sformatf("ch%0d_io_t", c), io_t[c], (m_st[c] != S_TX));
      check_val($sformatf("ch%0d_io_o", c), io_o[c], m_ioo[c]);
      check_val($sformatf("ch%0d_rx_valid", c), rx_valid[c], m_rxv[c]);
      check_val($sformatf("ch%0d_rx_word", c), rx_word[c*DP +: DP], m_rxw[c]);
      check_val($sformatf("ch%0d_dir_state", c), dir_state[2*c +: 2], m_st[c]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_io_t"}, io_t, {CH{1'b1}});
    check_val({tag, "_io_o"}, io_o, '0);
    check_val({tag, "_tx_ready"}, tx_ready, '0);
    check_val({tag, "_rx_valid"}, rx_valid, '0);
    check_val({tag, "_rx_word"}, rx_word, '0);
    check_val({tag, "_dir_state"}, dir_state, '0);
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic tick(input logic [CH-1:0] d, input logic [CH-1:0] v,
                      input logic [CH-1:0] i, input logic [CH*DP-1:0] w);
    dir_req = d; tx_valid = v; io_i = i; tx_word = w;
    #1;
    for (int c = 0; c < CH; c++)
      check_val($sformatf("ch%0d_tx_ready", c), tx_ready[c], m_ready(c, d[c]));
    model_step(d, v, i, w);
    @(negedge clk);
    compare_outputs();
  endtask

  function automatic logic [CH-1:0] rbits();
    logic [31:0] r;
    r = $urandom;
    return r[CH-1:0];
  endfunction

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1 check_reset_outputs(tag);
    model_reset();
    @(negedge clk);
    check_reset_outputs({tag, "_held"});
    reset = 1'b1;
  endtask

  task automatic random_run(input int n);
    logic [CH-1:0]    rd;
    logic [CH-1:0]    rv;
    logic [31:0]      r32;
    logic [CH*DP-1:0] rw;
    rd = '0;
    for (int t = 0; t < n; t++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 11) == 0) rd[c] = ~rd[c];
        rv[c] = ($urandom_range(0, 3) != 0);
      end
      r32 = $urandom;
      rw  = r32[CH*DP-1:0];
      tick(rd, rv, rbits(), rw);
    end
  endtask

  logic [7:0] seq;

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; dir_req = '0; tx_valid = '0; io_i = '0; tx_word = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;

    // receive 1,0,1,1 on both channels
    tick(2'b00, 2'b00, 2'b11, '0);
    tick(2'b00, 2'b00, 2'b00, '0);
    tick(2'b00, 2'b00, 2'b11, '0);
    tick(2'b00, 2'b00, 2'b11, '0);
    check_val("t1_rx_word", rx_word[DP-1:0], 4'b1011);
    check_val("t1_rx_valid", rx_valid[0], 1'b1);
    tick(2'b00, 2'b00, rbits(), '0);
    check_val("t1_rx_pulse_end", rx_valid[0], 1'b0);

    // channel 0 turns to transmit
    tick(2'b01, 2'b00, rbits(), '0);
    check_val("t2_state_a", dir_state[1:0], 2'd1);
    tick(2'b01, 2'b00, rbits(), '0);
    check_val("t2_state_b", dir_state[1:0], 2'd1);
    check_val("t2_io_t_dead", io_t[0], 1'b1);
    tick(2'b01, 2'b00, rbits(), '0);
    check_val("t2_state_tx", dir_state[1:0], 2'd2);
    check_val("t2_io_t_drive", io_t[0], 1'b0);

    // back-to-back words A then 5
    seq = '0;
    tick(2'b01, 2'b01, rbits(), {4'h0, 4'hA});
    seq = {seq[6:0], io_o[0]};
    for (int k = 0; k < 7; k++) begin
      tick(2'b01, 2'b01, rbits(), {4'h0, 4'h5});
      seq = {seq[6:0], io_o[0]};
    end
    check_val("t3_serial", seq, 8'hA5);
    tick(2'b01, 2'b00, rbits(), '0);

    // word C, direction dropped after its second bit
    tick(2'b01, 2'b01, rbits(), {4'h0, 4'hC});
    tick(2'b01, 2'b00, rbits(), '0);
    tick(2'b00, 2'b00, rbits(), '0);
    tick(2'b00, 2'b00, rbits(), '0);
    check_val("t4_last_bit_driven", io_t[0], 1'b0);
    tick(2'b00, 2'b00, rbits(), '0);
    check_val("t4_turn_rx", dir_state[1:0], 2'd3);
    tick(2'b00, 2'b00, rbits(), '0);
    tick(2'b00, 2'b00, rbits(), '0);
    check_val("t4_back_rx", dir_state[1:0], 2'd0);

    // one-cycle direction pulse aborts the turnaround
    tick(2'b00, 2'b00, rbits(), '0);
    tick(2'b00, 2'b00, rbits(), '0);
    tick(2'b01, 2'b00, rbits(), '0);
    tick(2'b00, 2'b00, rbits(), '0);
    check_val("t5_abort_rx", dir_state[1:0], 2'd0);
    check_val("t5_io_t", io_t[0], 1'b1);
    for (int k = 0; k < 5; k++) tick(2'b00, 2'b00, rbits(), '0);

    // reset while channel 0 is mid-word and channel 1 receives
    for (int k = 0; k < 3; k++) tick(2'b01, 2'b00, rbits(), '0);
    tick(2'b01, 2'b01, rbits(), {4'h0, 4'h9});
    tick(2'b01, 2'b00, rbits(), '0);
    async_reset("t6");
    for (int k = 0; k < 6; k++) tick(2'b00, 2'b00, rbits(), '0);

    random_run(1500);
    async_reset("rand_rst");
    random_run(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
